// File: rtl/tank_key_ctrl.sv
// Tank game key controller: turns {press, ascii} make/break events into per-player heading, move and fire.
// Optional build macro TANK_AUTOFIRE_EN: a held fire key re-fires every COOLDOWN cycles.
module tank_key_ctrl #(
    parameter int unsigned COOLDOWN = 25000000,
    parameter int unsigned CD_W     = 25
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    input  logic       press,
    input  logic [7:0] ascii,
    output logic [1:0] p1_dir,
    output logic       p1_move,
    output logic       p1_fire,
    output logic [1:0] p2_dir,
    output logic       p2_move,
    output logic       p2_fire
);

    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN - 1);

    logic       r_prev_press;
    logic [7:0] r_prev_ascii;
    logic       w_event;
    logic [1:0] w_dkey;
    logic [1:0] w_fkey;
    logic [1:0] w_idx;
    logic [1:0] w_dir_o  [2];
    logic       w_move_o [2];
    logic       w_fire_o [2];

    // Up > down > left > right among the keys still held
    function automatic logic [1:0] f_prio(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            r_prev_press <= 1'b0;
            r_prev_ascii <= 8'h00;
        end else begin
            r_prev_press <= press;
            r_prev_ascii <= ascii;
        end
    end

    assign w_event = ((press != r_prev_press) || (ascii != r_prev_ascii)) && (ascii != 8'h00);

    // Key map: direction bit index doubles as the heading code
    always_comb begin
        w_dkey = 2'b00;
        w_fkey = 2'b00;
        w_idx  = 2'd0;
        case (ascii)
            8'h77: begin w_dkey[0] = 1'b1; w_idx = 2'd0; end
            8'h73: begin w_dkey[0] = 1'b1; w_idx = 2'd1; end
            8'h61: begin w_dkey[0] = 1'b1; w_idx = 2'd2; end
            8'h64: begin w_dkey[0] = 1'b1; w_idx = 2'd3; end
            8'h20: w_fkey[0] = 1'b1;
            8'h69: begin w_dkey[1] = 1'b1; w_idx = 2'd0; end
            8'h6B: begin w_dkey[1] = 1'b1; w_idx = 2'd1; end
            8'h6A: begin w_dkey[1] = 1'b1; w_idx = 2'd2; end
            8'h6C: begin w_dkey[1] = 1'b1; w_idx = 2'd3; end
            8'h0D: w_fkey[1] = 1'b1;
            default: ;
        endcase
    end

    for (genvar g = 0; g < 2; g++) begin : g_player
        logic [3:0]      r_held;
        logic            r_fheld;
        logic [1:0]      r_dir;
        logic            r_move;
        logic            r_fire;
        logic [CD_W-1:0] r_cd;
        logic [3:0]      w_held_nxt;
        logic            w_fheld_nxt;
        logic [1:0]      w_dir_nxt;
        logic            w_fire_go;

        always_comb begin
            w_held_nxt  = r_held;
            w_fheld_nxt = r_fheld;
            w_dir_nxt   = r_dir;
            if (w_event && w_dkey[g]) begin
                w_held_nxt[w_idx] = press;
                if (press)
                    w_dir_nxt = w_idx;
                else if ((w_idx == r_dir) && (w_held_nxt != 4'b0000))
                    w_dir_nxt = f_prio(w_held_nxt);
            end
            if (w_event && w_fkey[g])
                w_fheld_nxt = press;
`ifdef TANK_AUTOFIRE_EN
            // Using the next held value suppresses a pulse in the break cycle
            w_fire_go = w_fheld_nxt && (r_cd == '0);
`else
            w_fire_go = w_event && w_fkey[g] && press && (r_cd == '0);
`endif
        end

        always_ff @(posedge clk_100mhz) begin
            if (rst) begin
                r_held  <= 4'b0000;
                r_fheld <= 1'b0;
                r_dir   <= 2'd0;
                r_move  <= 1'b0;
                r_fire  <= 1'b0;
                r_cd    <= '0;
            end else begin
                r_held  <= w_held_nxt;
                r_fheld <= w_fheld_nxt;
                r_dir   <= w_dir_nxt;
                r_move  <= |w_held_nxt;
                r_fire  <= w_fire_go;
                if (w_fire_go)
                    r_cd <= CD_LOAD;
                else if (r_cd != '0)
                    r_cd <= r_cd - CD_W'(1);
            end
        end

        assign w_dir_o[g]  = r_dir;
        assign w_move_o[g] = r_move;
        assign w_fire_o[g] = r_fire;
    end

    assign p1_dir  = w_dir_o[0];
    assign p1_move = w_move_o[0];
    assign p1_fire = w_fire_o[0];
    assign p2_dir  = w_dir_o[1];
    assign p2_move = w_move_o[1];
    assign p2_fire = w_fire_o[1];

endmodule

// File: tb/tb_tank_key_ctrl.sv
// Scoreboard bench for tank_key_ctrl: driver queues hand-computed per-cycle outputs, monitor checks them.
module tb_tank_key_ctrl;

    typedef struct packed {
        logic [1:0] d1;
        logic       m1;
        logic       f1;
        logic [1:0] d2;
        logic       m2;
        logic       f2;
    } outs_t;

    typedef struct {
        int    cyc;
        outs_t e;
        string tag;
    } exp_t;

    logic       clk_100mhz = 1'b0;
    logic       rst = 1'b1;
    logic       press = 1'b0;
    logic [7:0] ascii = 8'h00;
    logic [1:0] p1_dir, p2_dir;
    logic       p1_move, p1_fire, p2_move, p2_fire;

    int    cyc_cnt = 0;
    int    n_vec = 0;
    int    n_err = 0;
    string phase = "reset";
    exp_t  q[$];

    tank_key_ctrl #(.COOLDOWN(10), .CD_W(25)) dut (
        .clk_100mhz(clk_100mhz), .rst(rst), .press(press), .ascii(ascii),
        .p1_dir(p1_dir), .p1_move(p1_move), .p1_fire(p1_fire),
        .p2_dir(p2_dir), .p2_move(p2_move), .p2_fire(p2_fire)
    );

    always #5 clk_100mhz = ~clk_100mhz;
    always @(posedge clk_100mhz) cyc_cnt <= cyc_cnt + 1;

    function automatic outs_t o(input logic [1:0] d1, input logic m1, input logic f1,
                                input logic [1:0] d2, input logic m2, input logic f2);
        return outs_t'({d1, m1, f1, d2, m2, f2});
    endfunction

    // Inputs applied now are captured at the next edge; their result is visible in that cycle
    task automatic step(input logic r, input logic p, input logic [7:0] a, input outs_t e);
        exp_t x;
        @(posedge clk_100mhz);
        #1;
        rst   = r;
        press = p;
        ascii = a;
        x.cyc = cyc_cnt + 1;
        x.e   = e;
        x.tag = phase;
        q.push_back(x);
    endtask

    task automatic hold(input int n, input logic p, input logic [7:0] a, input outs_t e);
        for (int i = 0; i < n; i++) step(1'b0, p, a, e);
    endtask

    // Monitor: compare every queued expectation in its cycle
    initial begin
        outs_t act;
        forever begin
            @(negedge clk_100mhz);
            act = outs_t'({p1_dir, p1_move, p1_fire, p2_dir, p2_move, p2_fire});
            while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
                n_vec++;
                if (q[0].cyc < cyc_cnt) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: expectation not checked in its cycle", q[0].tag, q[0].cyc);
                end else if (act !== q[0].e) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got d1/m1/f1/d2/m2/f2=%b expected %b",
                             q[0].tag, cyc_cnt, act, q[0].e);
                end
                void'(q.pop_front());
            end
        end
    end

    initial begin
        outs_t z;
        z = o(2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        phase = "reset";
        step(1'b1, 1'b0, 8'h00, z);
        step(1'b1, 1'b0, 8'h00, z);

        phase = "p1_make_w";
        step(1'b0, 1'b1, 8'h77, o(0, 1, 0, 0, 0, 0));
        hold(2, 1'b1, 8'h77, o(0, 1, 0, 0, 0, 0));

        phase = "p1_last_wins";
        step(1'b0, 1'b1, 8'h64, o(3, 1, 0, 0, 0, 0));
        step(1'b0, 1'b1, 8'h64, o(3, 1, 0, 0, 0, 0));
        step(1'b0, 1'b0, 8'h64, o(0, 1, 0, 0, 0, 0));
        step(1'b0, 1'b0, 8'h77, o(0, 0, 0, 0, 0, 0));

        phase = "p1_priority";
        step(1'b0, 1'b1, 8'h61, o(2, 1, 0, 0, 0, 0));
        step(1'b0, 1'b1, 8'h73, o(1, 1, 0, 0, 0, 0));
        step(1'b0, 1'b1, 8'h64, o(3, 1, 0, 0, 0, 0));
        step(1'b0, 1'b0, 8'h73, o(3, 1, 0, 0, 0, 0));
        step(1'b0, 1'b0, 8'h64, o(2, 1, 0, 0, 0, 0));
        step(1'b0, 1'b1, 8'h77, o(0, 1, 0, 0, 0, 0));
        step(1'b0, 1'b1, 8'h73, o(1, 1, 0, 0, 0, 0));
        step(1'b0, 1'b0, 8'h73, o(0, 1, 0, 0, 0, 0));
        step(1'b0, 1'b0, 8'h77, o(2, 1, 0, 0, 0, 0));
        step(1'b0, 1'b0, 8'h61, o(2, 0, 0, 0, 0, 0));

        phase = "unmapped";
        step(1'b0, 1'b1, 8'h00, o(2, 0, 0, 0, 0, 0));
        step(1'b0, 1'b0, 8'h00, o(2, 0, 0, 0, 0, 0));
        step(1'b0, 1'b1, 8'h71, o(2, 0, 0, 0, 0, 0));
        step(1'b0, 1'b0, 8'h71, o(2, 0, 0, 0, 0, 0));

        phase = "two_players";
        step(1'b0, 1'b1, 8'h6C, o(2, 0, 0, 3, 1, 0));
        step(1'b0, 1'b1, 8'h77, o(0, 1, 0, 3, 1, 0));
        step(1'b0, 1'b1, 8'h0D, o(0, 1, 0, 3, 1, 1));
        step(1'b0, 1'b0, 8'h0D, o(0, 1, 0, 3, 1, 0));
        step(1'b0, 1'b1, 8'h6A, o(0, 1, 0, 2, 1, 0));
        step(1'b0, 1'b0, 8'h6A, o(0, 1, 0, 3, 1, 0));
        step(1'b0, 1'b0, 8'h6C, o(0, 1, 0, 3, 0, 0));
        step(1'b0, 1'b0, 8'h77, o(0, 0, 0, 3, 0, 0));

        phase = "p1_cooldown";
        step(1'b0, 1'b1, 8'h20, o(0, 0, 1, 3, 0, 0));
        hold(4, 1'b0, 8'h20, o(0, 0, 0, 3, 0, 0));
        step(1'b0, 1'b1, 8'h20, o(0, 0, 0, 3, 0, 0));
        hold(7, 1'b0, 8'h20, o(0, 0, 0, 3, 0, 0));
        step(1'b0, 1'b1, 8'h20, o(0, 0, 1, 3, 0, 0));
        step(1'b0, 1'b0, 8'h20, o(0, 0, 0, 3, 0, 0));
        hold(10, 1'b0, 8'h20, o(0, 0, 0, 3, 0, 0));

`ifdef TANK_AUTOFIRE_EN
        phase = "autofire_hold";
        for (int k = 0; k < 35; k++)
            step(1'b0, 1'b1, 8'h20, o(0, 0, (k % 10 == 0), 3, 0, 0));
        step(1'b0, 1'b0, 8'h20, o(0, 0, 0, 3, 0, 0));
        hold(10, 1'b0, 8'h20, o(0, 0, 0, 3, 0, 0));

        phase = "autofire_break_at_zero";
        step(1'b0, 1'b1, 8'h20, o(0, 0, 1, 3, 0, 0));
        hold(9, 1'b1, 8'h20, o(0, 0, 0, 3, 0, 0));
        step(1'b0, 1'b0, 8'h20, o(0, 0, 0, 3, 0, 0));
        hold(3, 1'b0, 8'h20, o(0, 0, 0, 3, 0, 0));
`else
        phase = "typematic_fire";
        step(1'b0, 1'b1, 8'h20, o(0, 0, 1, 3, 0, 0));
        hold(14, 1'b1, 8'h20, o(0, 0, 0, 3, 0, 0));
        step(1'b0, 1'b0, 8'h20, o(0, 0, 0, 3, 0, 0));
`endif
        hold(10, 1'b0, 8'h20, o(0, 0, 0, 3, 0, 0));

        phase = "reset_mid_cooldown";
        step(1'b0, 1'b1, 8'h6C, o(0, 0, 0, 3, 1, 0));
        step(1'b0, 1'b1, 8'h20, o(0, 0, 1, 3, 1, 0));
        step(1'b0, 1'b0, 8'h20, o(0, 0, 0, 3, 1, 0));
        step(1'b1, 1'b0, 8'h00, z);
        step(1'b0, 1'b1, 8'h20, o(0, 0, 1, 0, 0, 0));
        step(1'b0, 1'b0, 8'h20, z);
        hold(2, 1'b0, 8'h20, z);

        repeat (3) @(posedge clk_100mhz);
        #1;
        while (q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s cyc %0d: expectation never checked", q[0].tag, q[0].cyc);
            void'(q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
